// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M execute-stage controller; multiplies locally, sequences the external divider,
// and resolves divide-by-zero / signed-overflow without it.
module muldiv_unit #(
    parameter int MUL_PIPE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        div_start,
    output logic        div_sign,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        div_busy
);
    typedef enum logic [2:0] {IDLE, MUL, DIV_WAIT, DRAIN, RESP} state_t;
    state_t      state;
    logic [2:0]  op;
    logic [63:0] prod;
    logic [1:0]  cnt;
    logic        accept, div_zero, div_ovf;
    logic [63:0] a_ext, b_ext, full;

    assign req_ready    = reset_n && state == IDLE && !flush;
    assign accept       = req_valid && req_ready;
    assign div_zero     = req_rs2 == 32'd0;
    assign div_ovf      = !req_op[0] && req_rs1 == 32'h8000_0000 && req_rs2 == 32'hFFFF_FFFF;
    assign div_start    = accept && req_op[2] && !div_zero && !div_ovf;
    assign div_sign     = ~req_op[0];
    assign div_dividend = req_rs1;
    assign div_divisor  = req_rs2;
    // Extending both operands to 64 bits makes the low 64 product bits correct for every signedness mix
    assign a_ext = {{32{req_op != 3'd3 && req_rs1[31]}}, req_rs1};
    assign b_ext = {{32{!req_op[1] && req_rs2[31]}}, req_rs2};
    assign full  = a_ext * b_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op         <= 3'd0;
            prod       <= 64'd0;
            cnt        <= 2'd0;
            rsp_valid  <= 1'b0;
            rsp_result <= 32'd0;
        end else if (flush) begin
            // The divider cannot abort, so a killed divide must drain before the unit reopens
            state     <= (state == DIV_WAIT || (state == DRAIN && div_busy)) ? DRAIN : IDLE;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op  <= req_op;
                    cnt <= 2'd0;
                    if (!req_op[2]) begin
                        prod  <= full;
                        state <= MUL;
                    end else if (div_zero || div_ovf) begin
                        rsp_result <= div_zero ? (req_op[1] ? req_rs1 : 32'hFFFF_FFFF)
                                               : (req_op[1] ? 32'd0 : 32'h8000_0000);
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= DIV_WAIT;
                    end
                end
                MUL: if (cnt == 2'(MUL_PIPE - 1)) begin
                    rsp_result <= op == 3'd0 ? prod[31:0] : prod[63:32];
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end else begin
                    cnt <= cnt + 2'd1;
                end
                DIV_WAIT: if (!div_busy) begin
                    rsp_result <= op[1] ? div_remainder : div_quotient;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                DRAIN: if (!div_busy) state <= IDLE;
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against a behavioural iterative divider with an operand cache;
// a scoreboard queue holds expected results and latencies checked by an independent monitor.
module tb_muldiv_unit;
    logic        clk = 0, reset_n = 0;
    logic        req_valid = 0, req_ready, flush = 0, rsp_valid, rsp_ready = 1;
    logic [2:0]  req_op = 0;
    logic [31:0] req_rs1 = 0, req_rs2 = 0, rsp_result;
    logic        div_start, div_sign, div_busy;
    logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;

    muldiv_unit #(.MUL_PIPE(1)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .div_start(div_start), .div_sign(div_sign), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    // Divider: busy for 33 cycles after a start, unless the operands match the last completed op
    logic [31:0] c_a, c_b;
    logic        c_s, c_ok;
    int          d_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_busy <= 0; d_cnt <= 0; c_ok <= 0; c_a <= 0; c_b <= 0; c_s <= 0;
            div_quotient <= 0; div_remainder <= 0;
        end else if (div_start && !(c_ok && c_a == div_dividend && c_b == div_divisor && c_s == div_sign)) begin
            div_busy <= 1; d_cnt <= 33; c_ok <= 0;
            c_a <= div_dividend; c_b <= div_divisor; c_s <= div_sign;
        end else if (div_busy) begin
            if (d_cnt == 1) begin
                div_busy      <= 0;
                c_ok          <= 1;
                div_quotient  <= c_s ? 32'($signed(c_a) / $signed(c_b)) : c_a / c_b;
                div_remainder <= c_s ? 32'($signed(c_a) % $signed(c_b)) : c_a % c_b;
            end
            d_cnt <= d_cnt - 1;
        end
    end

    int tests = 0, fails = 0, cyc = 0, starts = 0;
    logic [31:0] exp_q[$];
    int lat_q[$], acc_q[$], id_q[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (div_start) starts++;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endfunction

    bit seen = 0;
    int first = 0;
    always @(negedge clk) begin
        if (!reset_n) seen = 0;
        else begin
            if (rsp_valid && !seen) begin seen = 1; first = cyc; end
            if (rsp_valid && rsp_ready) begin
                seen = 0;
                if (exp_q.size() == 0) chk("unexpected_rsp", rsp_result, 32'hx);
                else begin
                    automatic logic [31:0] e = exp_q.pop_front();
                    automatic int l = lat_q.pop_front(), a = acc_q.pop_front(), id = id_q.pop_front();
                    chk($sformatf("result_%0d", id), rsp_result, e);
                    chk($sformatf("latency_%0d", id), 32'(first - a), 32'(l));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, b, e, input int lat, input bit push, input int id);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b;
        do begin @(negedge clk); n++; end while (!req_ready && n < 300);
        if (!req_ready) chk($sformatf("accept_timeout_%0d", id), 32'd0, 32'd1);
        else if (push) begin
            exp_q.push_back(e); lat_q.push_back(lat); acc_q.push_back(cyc); id_q.push_back(id);
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    initial begin
        int s0, viol, n;
        bit ok;
        #12;
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_div_start", 32'(div_start), 0);
        @(posedge clk); #2 reset_n = 1;
        #1 chk("idle_req_ready", 32'(req_ready), 1);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1, 1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1, 2);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2, 1, 3);
        issue(3'd0, 32'd7,         32'd6,         32'd42,        2, 1, 4);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35, 1, 5);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 2, 1, 6);
        s0 = starts;
        issue(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1, 7);
        issue(3'd6, 32'd5,         32'd0,         32'd5,         1, 1, 8);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 9);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1, 10);
        chk("special_no_div_start", 32'(starts - s0), 0);

        // Response held off for 10 cycles
        @(posedge clk); #1 rsp_ready = 0;
        issue(3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, 2, 1, 11);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_result !== 32'd1 || req_ready) viol++;
        end
        chk("hold_stable", 32'(viol), 0);
        @(posedge clk); #1 rsp_ready = 1;

        // Flush during a divide: no response, drain until the divider goes idle
        issue(3'd5, 32'd100, 32'd3, 32'd0, 0, 0, 12);
        repeat (4) @(posedge clk);
        #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        chk("flush_div_busy", 32'(div_busy), 1);
        viol = 0; ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (div_busy && req_ready) viol++;
            if (!div_busy && req_ready) ok = 1;
        end
        chk("drain_ready_while_busy", 32'(viol), 0);
        chk("drain_ready_returns", 32'(ok), 1);
        issue(3'd0, 32'd3, 32'd3, 32'd9, 2, 1, 13);

        // Reset in DIV_WAIT clears the response registers immediately
        issue(3'd4, 32'd100, 32'd7, 32'd0, 0, 0, 14);
        repeat (3) @(posedge clk);
        #3 reset_n = 0;
        #1;
        chk("async_reset_rsp_valid", 32'(rsp_valid), 0);
        chk("async_reset_rsp_result", rsp_result, 0);
        @(posedge clk); #2 reset_n = 1;
        issue(3'd4, 32'd100, 32'd7, 32'd14, 35, 1, 15);

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
